// File: rtl/ex_stage_pipe_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline register.
// State encoding, default widths and the packed entry layout.
package ex_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 5;

  typedef struct packed {
    logic                  wr_en;
    logic [DEST_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] alu_result;
  } ex_mem_t;

  function automatic int entry_w(input int data_w, input int dest_w);
    return 1 + dest_w + data_w;
  endfunction

endpackage

// File: rtl/ex_stage_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ex_stage_pipe_reg.sv
// EX->MEM pipeline register: 2-entry skid buffer or single register,
// with synchronous flush and a saturating output-stall counter.
module ex_stage_pipe_reg
  import ex_pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEST_W      = DEST_W_DEF,
  parameter int SKID_EN     = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_alu_result,
  input  logic [DEST_W-1:0]      in_dest,
  input  logic                   in_wr_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_alu_result,
  output logic [DEST_W-1:0]      out_dest,
  output logic                   out_wr_en,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int ENT_W = entry_w(DATA_W, DEST_W);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             rdy_q;
  logic [ENT_W-1:0] main_q;
  logic [ENT_W-1:0] skid_q;
  logic [ENT_W-1:0] in_ent;
  logic             accept;
  logic             xfer;
  logic             ld_main_in;
  logic             ld_main_skid;
  logic             ld_skid;

  assign in_ent    = {in_wr_en, in_dest, in_alu_result};
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (SKID_EN != 0) ? rdy_q
                                    : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // in_ready is precomputed from next state so MEM's ready never
  // reaches EX combinationally in skid mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (1'b1)
        (state_q == ST_EMPTY): begin
          if (accept) state_d = ST_ONE;
        end
        (state_q == ST_ONE): begin
          if (xfer && !accept)      state_d = ST_EMPTY;
          else if (accept && !xfer) state_d = ST_TWO;
        end
        (state_q == ST_TWO): begin
          if (xfer) state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (!flush) begin
      unique case (1'b1)
        (state_q == ST_EMPTY): ld_main_in = accept;
        (state_q == ST_ONE): begin
          ld_main_in = accept && xfer;
          ld_skid    = accept && !xfer;
        end
        (state_q == ST_TWO): ld_main_skid = xfer;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_ent;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_ent;
    end
  end

  assign {out_wr_en, out_dest, out_alu_result} = main_q;

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall (
    .clock (clock),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .count (stall_count)
  );

endmodule

// File: tb/tb_ex_stage_pipe_reg.sv
// Scoreboard bench: skid and single-register instances share stimulus,
// each checked against its own reference queue.
module tb_ex_stage_pipe_reg;

  localparam int SW = 4;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [4:0]  in_dest;
  logic        in_wr_en;
  logic        out_ready;

  logic          a_in_ready, a_out_valid, a_we;
  logic [31:0]   a_res;
  logic [4:0]    a_dest;
  logic [SW-1:0] a_stall;
  logic          b_in_ready, b_out_valid, b_we;
  logic [31:0]   b_res;
  logic [4:0]    b_dest;
  logic [SW-1:0] b_stall;

  ex_stage_pipe_reg #(
    .DATA_W(32), .DEST_W(5), .SKID_EN(1), .STALL_CNT_W(SW)
  ) u_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_alu_result(in_alu_result), .in_dest(in_dest),
    .in_wr_en(in_wr_en), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_alu_result(a_res),
    .out_dest(a_dest), .out_wr_en(a_we), .stall_count(a_stall)
  );

  ex_stage_pipe_reg #(
    .DATA_W(32), .DEST_W(5), .SKID_EN(0), .STALL_CNT_W(SW)
  ) u_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_alu_result(in_alu_result), .in_dest(in_dest),
    .in_wr_en(in_wr_en), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_alu_result(b_res),
    .out_dest(b_dest), .out_wr_en(b_we), .stall_count(b_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [37:0]   qa[$];
  logic [37:0]   qb[$];
  logic [SW-1:0] sa = '0;
  logic [SW-1:0] sb = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic fl,
                      input logic iv, input logic [31:0] d,
                      input logic [4:0] ds, input logic we,
                      input logic ordy);
    logic ra, rb, xa, xb;
    logic [37:0] ent;
    reset = rst; flush = fl; in_valid = iv;
    in_alu_result = d; in_dest = ds; in_wr_en = we;
    out_ready = ordy;
    ent = {we, ds, d};
    #1;
    ra = (qa.size() < 2);
    rb = (qb.size() == 0) || ordy;
    check("a_in_ready", 64'(a_in_ready), 64'(ra));
    check("b_in_ready", 64'(b_in_ready), 64'(rb));
    check("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
    check("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
    if (qa.size() > 0)
      check("a_out", 64'({a_we, a_dest, a_res}), 64'(qa[0]));
    if (qb.size() > 0)
      check("b_out", 64'({b_we, b_dest, b_res}), 64'(qb[0]));
    check("a_stall", 64'(a_stall), 64'(sa));
    check("b_stall", 64'(b_stall), 64'(sb));
    @(posedge clock);
    xa = (qa.size() > 0) && ordy;
    xb = (qb.size() > 0) && ordy;
    if (rst) begin
      qa.delete(); qb.delete(); sa = '0; sb = '0;
    end else begin
      if (qa.size() > 0 && !ordy && sa != '1) sa++;
      if (qb.size() > 0 && !ordy && sb != '1) sb++;
      if (fl) begin
        qa.delete(); qb.delete();
      end else begin
        if (xa) void'(qa.pop_front());
        if (xb) void'(qb.pop_front());
        if (iv && ra) qa.push_back(ent);
        if (iv && rb) qb.push_back(ent);
      end
    end
    #1;
  endtask

  task automatic feed(input logic [31:0] d, input logic ordy);
    step(1'b0, 1'b0, 1'b1, d, d[4:0], d[0], ordy);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0, ordy);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 64'({a_out_valid, a_we, a_dest, a_res, a_stall}),
          64'(0));
    check({tag, "_b"}, 64'({b_out_valid, b_we, b_dest, b_res, b_stall}),
          64'(0));
    check({tag, "_rdy"}, 64'(a_in_ready), 64'(1));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_alu_result = '0; in_dest = '0; in_wr_en = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");

    // streaming at full rate
    feed(32'h11, 1'b1);
    feed(32'h22, 1'b1);
    feed(32'h33, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // backpressure fills the skid entry
    feed(32'hA0, 1'b0);
    feed(32'hA1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush while two entries held; 0xBEEF must be dropped
    feed(32'hB0, 1'b0);
    feed(32'hB1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'hBEEF, 5'h3, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // stall counter saturation, survives flush, cleared by reset
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    feed(32'hC0, 1'b0);
    repeat (20) idle(1'b0);
    check("a_stall_sat", 64'(a_stall), 64'(15));
    step(1'b0, 1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    idle(1'b1);
    check("a_stall_flush", 64'(a_stall), 64'(15));
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    check_zero("reset2");

    // single-register mode: combinational ready
    feed(32'hD0, 1'b0);
    idle(1'b0);
    feed(32'h5, 1'b1);
    idle(1'b1);

    // reset while two entries held
    feed(32'hE0, 1'b0);
    feed(32'hE1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    check_zero("reset3");
    feed(32'hF0, 1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'b0, ($urandom_range(0, 19) == 0),
           1'($urandom), $urandom, 5'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_stage_pipe_reg.md
Name: ex_stage_pipe_reg

Overview:
- Parametrised EX→MEM pipeline register carrying ALU result, destination register index and write-enable, with a valid/ready handshake on both sides.
- Default mode is a 2-entry skid buffer: registered in_ready, full throughput, no combinational ready path from MEM back to EX.
- Also provides a synchronous flush for branch/exception squash, and a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 32, width of ALU result field.
- DEST_W, 5, width of destination register index.
- SKID_EN, 1. 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  squash all held entries; synchronous.
- in_valid  input  1  EX stage presents a valid result.
- in_ready  output  1  block can accept this cycle.
- in_alu_result  input  DATA_W  ALU result from EX.
- in_dest  input  DEST_W  destination register index.
- in_wr_en  input  1  register-file write enable for this instruction.
- out_valid  output  1  MEM-side entry valid.
- out_ready  input  1  MEM stage accepts this cycle.
- out_alu_result  output  DATA_W  held ALU result.
- out_dest  output  DEST_W  held destination index.
- out_wr_en  output  1  held write enable.
- stall_count  output  STALL_CNT_W  saturating count of output-stall cycles.

Behaviour:
- Interface reset and clock: reset reset, synchronous, active-high; clock clock.
- Handshakes: input accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Reset values: out_valid=0, out_alu_result=0, out_dest=0, out_wr_en=0, stall_count=0. With SKID_EN=1, in_ready=1 in the first cycle after reset; the skid register and its valid bit are 0.
- Latency: 1 cycle. Data accepted at edge N appears on out_* with out_valid=1 after edge N. Sustained throughput is 1 per cycle when out_ready stays high.
- SKID_EN=1 state machine, states EMPTY / ONE / TWO:
  - EMPTY, accept: main<=in, go to ONE.
  - ONE, accept and transfer: main<=in, stay in ONE.
  - ONE, accept without transfer: skid<=in, go to TWO.
  - ONE, transfer without accept: go to EMPTY.
  - TWO, transfer: main<=skid, go to ONE. No accept is possible in TWO because in_ready=0.
- in_ready is a registered output: 1 in EMPTY and ONE, 0 in TWO. It has no combinational dependence on out_ready.
- SKID_EN=0: single register. in_ready = !out_valid || out_ready (combinational). Accept loads main. Transfer without accept clears out_valid.
- Ordering: out_* always shows the oldest entry. Entries are never reordered or duplicated.
- Stability: while out_valid && !out_ready, all out_* fields hold their value unchanged.
- Flush:
  - At the next edge, out_valid=0, skid cleared, state EMPTY, in_ready=1.
  - An input presented in the flush cycle is dropped, even if in_valid && in_ready.
  - A transfer in the flush cycle still counts as completed; MEM consumed it.
  - Flush has priority over accept.
  - Data fields may retain stale values after flush; only the valid bits matter.
- Reset has priority over flush. Reset mid-stream discards all entries.
- stall_count:
  - Increments by 1 each cycle with out_valid && !out_ready.
  - Saturates at 2^STALL_CNT_W−1 and does not wrap.
  - Cleared only by reset, not by flush.
- out_wr_en is meaningful only when out_valid=1. The downstream stage must qualify it with out_valid.

Decomposition:
- Package ex_pipe_pkg holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - default widths DATA_W_DEF=32, DEST_W_DEF=5;
  - a packed entry layout of {wr_en, dest, alu_result}.
- One natural sub-module: sat_counter (parameter W; ports inc and count; synchronous reset; saturating), instantiated for stall_count.

Test Plan:
- Reset then stream: hold out_ready=1 and feed 0x11,0x22,0x33 on consecutive cycles. Expect out_alu_result 0x11,0x22,0x33 one cycle later each, in_ready constantly 1, stall_count=0.
- Backpressure (SKID_EN=1): out_ready=0, feed 0xA0 then 0xA1. Expect in_ready=0 after the second accept, out holds 0xA0 and stays stable. Then raise out_ready. Expect 0xA0, then 0xA1, in_ready=1 again, no loss or duplication.
- Flush while in TWO, with in_valid=1 and data 0xBEEF in the flush cycle. Expect out_valid=0 next cycle, 0xBEEF never appears at the output, in_ready=1.
- Stall counter saturation with STALL_CNT_W=4: 20 cycles of out_valid=1, out_ready=0. Expect stall_count to stick at 15. A following flush leaves it at 15. A reset clears it to 0.
- SKID_EN=0 mode: out_ready=0 with out_valid=1. Expect in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1, in=0x5. Expect in_ready=1 combinationally and out=0x5 next cycle.
- Reset mid-operation: assert reset while in TWO with out_ready=0. Expect all outputs zero next cycle, in_ready=1, and the first post-reset accept emerging after exactly 1 cycle.
